bsearch_param: RTL and testbench

Parametrised binary-search engine that locates a key in an externally owned, ascending-sorted, single-port synchronous RAM of 2^ADDR_W words. It is the parametrised successor to the lab's fixed 32x8 exact-match searcher. It adds three things: configurable data width, depth and RAM read latency; a lower-bound mode that returns the first occurrence, or the insertion point when the key is absent; and a probe counter for performance checks. The engine sits between the lab's control FSM or switch front-end and a ROM/RAM preloaded from a MIF. It never writes memory.

---
 rtl/bsearch_param.sv | 156 +++++++++++++++
 tb/tb_bsearch_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bsearch_param.sv
`default_nettype none
// ============================================================================
// Module   : bsearch_param
// Purpose  : Binary search over an external ascending-sorted synchronous RAM,
//            with exact and lower-bound modes and a probe counter.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module bsearch_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] A,
  input  logic              Mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   Loc,
  output logic              Found,
  output logic              Done,
  output logic              Busy,
  output logic [ADDR_W:0]   Probes
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_PROBE   = 2'd1;
  localparam logic [1:0] c_COMPARE = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  localparam logic [ADDR_W:0] c_DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [2:0]      c_WAIT_LAST = 3'(RD_LAT - 1);

  logic [1:0]        state_q,  state_d;
  logic [ADDR_W:0]   lo_q,     lo_d;
  logic [ADDR_W:0]   hi_q,     hi_d;
  logic [DATA_W-1:0] key_q,    key_d;
  logic              mode_q,   mode_d;
  logic              found_q,  found_d;
  logic              done_q,   done_d;
  logic [ADDR_W:0]   loc_q,    loc_d;
  logic [ADDR_W:0]   probes_q, probes_d;
  logic [2:0]        wait_q,   wait_d;

  // Extra sum bit keeps lo+hi from wrapping when hi equals the depth.
  logic [ADDR_W+1:0] w_sum;
  logic [ADDR_W:0]   w_mid;
  logic [ADDR_W:0]   w_mid_p1;
  logic              w_unused;

  assign w_sum    = {1'b0, lo_q} + {1'b0, hi_q};
  assign w_mid    = w_sum[ADDR_W+1:1];
  assign w_mid_p1 = w_mid + (ADDR_W+1)'(1);
  assign w_unused = w_sum[0];

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    key_d    = key_q;
    mode_d   = mode_q;
    found_d  = found_q;
    done_d   = done_q;
    loc_d    = loc_q;
    probes_d = probes_q;
    wait_d   = wait_q;
    case (state_q)
      c_IDLE: begin
        if (Start) begin
          key_d    = A;
          mode_d   = Mode;
          lo_d     = '0;
          hi_d     = c_DEPTH;
          probes_d = '0;
          found_d  = 1'b0;
          wait_d   = '0;
          state_d  = c_PROBE;
        end
      end
      c_PROBE: begin
        if (wait_q == c_WAIT_LAST) begin
          state_d = c_COMPARE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      c_COMPARE: begin
        probes_d = probes_q + (ADDR_W+1)'(1);
        wait_d   = '0;
        state_d  = c_PROBE;
        if (mem_rdata < key_q) begin
          lo_d = w_mid_p1;
        end else if (mem_rdata > key_q) begin
          hi_d = w_mid;
        end else begin
          found_d = 1'b1;
          if (!mode_q) begin
            loc_d   = w_mid;
            state_d = c_DONE;
          end else begin
            hi_d = w_mid;
          end
        end
        if (state_d != c_DONE && lo_d >= hi_d) begin
          loc_d   = lo_d;
          state_d = c_DONE;
        end
      end
      c_DONE: begin
        // First DONE cycle registers the result flag; release only once it is visible.
        done_d = 1'b1;
        if (done_q && !Start) begin
          done_d  = 1'b0;
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= c_IDLE;
      lo_q     <= '0;
      hi_q     <= c_DEPTH;
      key_q    <= '0;
      mode_q   <= 1'b0;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
      loc_q    <= '0;
      probes_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      found_q  <= found_d;
      done_q   <= done_d;
      loc_q    <= loc_d;
      probes_q <= probes_d;
      wait_q   <= wait_d;
    end
  end

  assign mem_addr = w_mid[ADDR_W-1:0];
  assign Loc      = loc_q;
  assign Found    = found_q;
  assign Done     = done_q;
  assign Busy     = (state_q == c_PROBE) || (state_q == c_COMPARE);
  assign Probes   = probes_q;

endmodule
`default_nettype wire

// File: tb/tb_bsearch_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsearch_param
// Purpose  : Self-checking bench for bsearch_param (default and 12/4/2 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsearch_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset;

  logic       Start0, Mode0, Found0, Done0, Busy0;
  logic [7:0] A0, rdata0;
  logic [4:0] addr0;
  logic [5:0] Loc0, Probes0;
  logic [7:0] mem0 [32];

  logic        Start1, Mode1, Found1, Done1, Busy1;
  logic [11:0] A1, rdata1, pipe1;
  logic [3:0]  addr1;
  logic [4:0]  Loc1, Probes1;
  logic [11:0] mem1 [16];

  always @(posedge clk) rdata0 <= mem0[addr0];
  always @(posedge clk) begin
    pipe1  <= mem1[addr1];
    rdata1 <= pipe1;
  end

  bsearch_param dut0 (
    .clk(clk), .Reset(Reset), .Start(Start0), .A(A0), .Mode(Mode0),
    .mem_addr(addr0), .mem_rdata(rdata0), .Loc(Loc0), .Found(Found0),
    .Done(Done0), .Busy(Busy0), .Probes(Probes0)
  );

  bsearch_param #(.DATA_W(12), .ADDR_W(4), .RD_LAT(2)) dut1 (
    .clk(clk), .Reset(Reset), .Start(Start1), .A(A1), .Mode(Mode1),
    .mem_addr(addr1), .mem_rdata(rdata1), .Loc(Loc1), .Found(Found1),
    .Done(Done1), .Busy(Busy1), .Probes(Probes1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first index whose entry is >= key, or 32 if none.
  function automatic int lower_bound0(input logic [7:0] key);
    for (int i = 0; i < 32; i++) if (mem0[i] >= key) return i;
    return 32;
  endfunction

  task automatic run0(input logic [7:0] key, input logic mode, input int hold,
                      output logic [5:0] loc, output logic found,
                      output logic [5:0] probes, output int lat);
    int cyc;
    int held;
    Start0 = 1'b1;
    A0     = key;
    Mode0  = mode;
    step();
    A0    = 8'($urandom);
    Mode0 = 1'($urandom);
    cyc   = 0;
    while (Done0 !== 1'b1 && cyc < 200) begin
      step();
      cyc++;
    end
    if (cyc >= 200) check_eq("done0 timeout", cyc, 0);
    loc    = Loc0;
    found  = Found0;
    probes = Probes0;
    lat    = cyc;
    held   = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (Done0 === 1'b1 && Loc0 === loc && Found0 === found) held++;
    end
    if (hold > 0) check_eq("done0 held", held, hold);
    Start0 = 1'b0;
    step();
  endtask

  logic [5:0] loc, probes;
  logic       found, mode;
  logic [7:0] key;
  int         lat, cyc, v, exp_lb;
  logic       exp_found;
  logic [3:0] trace [$];
  int         exp_a [4];

  initial begin
    Reset = 1'b1;
    Start0 = 1'b0; A0 = '0; Mode0 = 1'b0;
    Start1 = 1'b0; A1 = '0; Mode1 = 1'b0;
    for (int i = 0; i < 32; i++) mem0[i] = 8'(2 * i + 1);
    for (int i = 0; i < 16; i++) mem1[i] = 12'(100 * i);
    repeat (3) step();
    Reset = 1'b0;
    check_eq("rst Done",   Done0,   0);
    check_eq("rst Found",  Found0,  0);
    check_eq("rst Busy",   Busy0,   0);
    check_eq("rst Loc",    Loc0,    0);
    check_eq("rst Probes", Probes0, 0);
    check_eq("rst addr",   addr0,   16);
    check_eq("rst addr1",  addr1,   8);

    run0(8'd33, 1'b0, 10, loc, found, probes, lat);
    check_eq("m0 33 loc", loc, 16);
    check_eq("m0 33 found", found, 1);
    check_eq("m0 33 probes", probes, 1);
    check_eq("m0 33 latency", lat, 3);

    run0(8'd34, 1'b1, 0, loc, found, probes, lat);
    check_eq("m1 34 loc", loc, 17);
    check_eq("m1 34 found", found, 0);
    check_eq("m1 34 probes<=6", probes <= 6, 1);
    run0(8'd0, 1'b1, 0, loc, found, probes, lat);
    check_eq("m1 0 loc", loc, 0);
    check_eq("m1 0 found", found, 0);
    check_eq("m1 0 probes<=6", probes <= 6, 1);
    run0(8'd100, 1'b1, 0, loc, found, probes, lat);
    check_eq("m1 100 loc", loc, 32);
    check_eq("m1 100 found", found, 0);
    check_eq("m1 100 probes<=6", probes <= 6, 1);

    for (int i = 0; i < 32; i++) mem0[i] = 8'd5;
    run0(8'd5, 1'b0, 0, loc, found, probes, lat);
    check_eq("all5 m0 loc", loc, 16);
    check_eq("all5 m0 found", found, 1);
    check_eq("all5 m0 probes", probes, 1);
    run0(8'd5, 1'b1, 0, loc, found, probes, lat);
    check_eq("all5 m1 loc", loc, 0);
    check_eq("all5 m1 found", found, 1);
    check_eq("all5 m1 probes", probes, 6);
    check_eq("all5 m1 latency", lat, 13);
    for (int i = 0; i < 32; i++) mem0[i] = 8'(2 * i + 1);

    // Abort during the third probe of a search for A=1.
    Start0 = 1'b1; A0 = 8'd1; Mode0 = 1'b0;
    step();
    Start0 = 1'b0;
    repeat (4) step();
    check_eq("p3 busy", Busy0, 1);
    check_eq("p3 addr", addr0, 4);
    check_eq("p3 probes", Probes0, 2);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check_eq("abort Done", Done0, 0);
    check_eq("abort Busy", Busy0, 0);
    check_eq("abort addr", addr0, 16);
    run0(8'd1, 1'b0, 0, loc, found, probes, lat);
    check_eq("post-rst loc", loc, 0);
    check_eq("post-rst found", found, 1);

    run0(8'd1, 1'b0, 0, loc, found, probes, lat);
    check_eq("b2b 1 loc", loc, 0);
    check_eq("b2b 1 found", found, 1);
    run0(8'd63, 1'b0, 0, loc, found, probes, lat);
    check_eq("b2b 63 loc", loc, 31);
    check_eq("b2b 63 found", found, 1);

    // 12-bit / 16-deep / 2-cycle RAM: probe path 8,4,6,7 for key 700.
    exp_a = '{8, 4, 6, 7};
    Start1 = 1'b1; A1 = 12'd700; Mode1 = 1'b0;
    step();
    A1 = 12'd5; Mode1 = 1'b1;
    cyc = 0;
    while (Done1 !== 1'b1 && cyc < 200) begin
      if (Busy1 === 1'b1) trace.push_back(addr1);
      step();
      cyc++;
    end
    if (cyc >= 200) check_eq("done1 timeout", cyc, 0);
    check_eq("w12 loc", Loc1, 7);
    check_eq("w12 found", Found1, 1);
    check_eq("w12 probes", Probes1, 4);
    check_eq("w12 latency", cyc, 1 + 32'(Probes1) * 3);
    check_eq("w12 busy cycles", trace.size(), 12);
    if (trace.size() == 12)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 3; j++) check_eq("w12 addr", trace[3 * k + j], exp_a[k]);
    Start1 = 1'b0;
    step();

    for (int b = 0; b < 5; b++) begin
      v = $urandom_range(0, 20);
      for (int i = 0; i < 32; i++) begin
        mem0[i] = 8'(v);
        v += $urandom_range(0, 3);
      end
      for (int s = 0; s < 8; s++) begin
        key  = ($urandom_range(0, 1) == 1) ? mem0[$urandom_range(0, 31)] : 8'($urandom_range(0, 130));
        mode = 1'($urandom);
        run0(key, mode, 0, loc, found, probes, lat);
        exp_lb    = lower_bound0(key);
        exp_found = (exp_lb < 32) && (mem0[exp_lb[4:0]] == key);
        check_eq("rnd found", found, exp_found);
        if (mode || !exp_found) check_eq("rnd loc", loc, exp_lb);
        else check_eq("rnd hit entry", (loc < 6'd32) ? 32'(mem0[loc[4:0]]) : 32'hFFFF, key);
        check_eq("rnd probes range", (probes >= 1) && (probes <= 6), 1);
        check_eq("rnd latency", lat, 1 + 32'(probes) * 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
